// File: rtl/ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ring_rr_arbiter
// Description : N-way round-robin arbiter with a one-hot ring priority
//               pointer, registered one-hot grant and bounded hold time
//               with forced rotation (pre-emption) when others are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    localparam int ID_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            preempt
);

    localparam int                    c_hold_w   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_hold_w-1:0]   c_hold_max = c_hold_w'(MAX_HOLD - 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0]          r_state;
    logic [N-1:0]        r_prio;
    logic [c_hold_w-1:0] r_hold;
    logic [N-1:0]        r_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_busy;
    logic                r_preempt;

    logic [0:0]          w_state_nxt;
    logic [N-1:0]        w_prio_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [N-1:0]        w_grant_nxt;
    logic                w_preempt_nxt;

    logic                w_owner_req;
    logic [N-1:0]        w_others;
    logic [N-1:0]        w_rot;
    logic [N-1:0]        w_win_idle;
    logic [N-1:0]        w_win_sw;

    function automatic logic [ID_W-1:0] f_onehot_idx(input logic [N-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    // Circular search: first the bits at or above the pointer, then the wrap.
    function automatic logic [N-1:0] f_pick(input logic [N-1:0] cand,
                                            input logic [N-1:0] prio);
        logic [ID_W-1:0] p;
        logic [N-1:0]    res;
        logic            found;
        p     = f_onehot_idx(prio);
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && cand[i] && (i >= int'(p))) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && cand[i] && (i < int'(p))) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_owner_req = |(req & r_grant);
    assign w_others    = req & ~r_grant;
    assign w_rot       = {r_grant[N-2:0], r_grant[N-1]};
    assign w_win_idle  = f_pick(req, r_prio);
    // On release req[g] is already low, so req & ~grant equals req there too.
    assign w_win_sw    = f_pick(w_others, w_rot);

    always_comb begin
        w_state_nxt   = r_state;
        w_prio_nxt    = r_prio;
        w_hold_nxt    = r_hold;
        w_grant_nxt   = r_grant;
        w_preempt_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (|req) begin
                    w_grant_nxt = w_win_idle;
                    w_hold_nxt  = '0;
                    w_state_nxt = c_st_grant;
                end
            end
            c_st_grant: begin
                if (!w_owner_req) begin
                    w_prio_nxt = w_rot;
                    w_hold_nxt = '0;
                    if (|w_others) begin
                        w_grant_nxt = w_win_sw;
                    end else begin
                        w_grant_nxt = '0;
                        w_state_nxt = c_st_idle;
                    end
                end else if ((r_hold == c_hold_max) && (|w_others)) begin
                    w_prio_nxt    = w_rot;
                    w_grant_nxt   = w_win_sw;
                    w_hold_nxt    = '0;
                    w_preempt_nxt = 1'b1;
                end else if (r_hold != c_hold_max) begin
                    w_hold_nxt = r_hold + c_hold_w'(1);
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_prio     <= {{(N-1){1'b0}}, 1'b1};
            r_hold     <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_hold     <= w_hold_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= f_onehot_idx(w_grant_nxt);
            r_busy     <= |w_grant_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign preempt  = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_ring_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_rr_arbiter
// Description : Directed scenarios plus randomized run against a queue-free
//               integer model of the round-robin rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic         preempt;

    int n_checks;
    int n_pass;

    // Model: owner index (-1 idle), search start, cycles held, preempt flag.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_pre;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] cand, input int from);
        for (int k = 0; k < N; k++) begin
            if (cand[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] others;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_pre = 1'b0;
        end else if (m_owner < 0) begin
            m_pre   = 1'b0;
            m_owner = pick(r, m_ptr);
            m_held  = 1;
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(r, m_ptr);
                m_held  = 1;
                m_pre   = 1'b0;
            end else if (m_held >= MAX_HOLD && others != 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(others, m_ptr);
                m_held  = 1;
                m_pre   = 1'b1;
            end else begin
                m_held++;
                m_pre = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic rs);
        req   = r;
        reset = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
    endtask

    task automatic test_reset;
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        n_checks++;
        if (grant === 4'b0000 && grant_id === 2'd0 && busy === 1'b0 && preempt === 1'b0) n_pass++;
        else $display("FAIL reset_state: grant=%b id=%0d busy=%b pre=%b, want 0000/0/0/0", grant, grant_id, busy, preempt);
        tick(4'b0101, 1'b0);
        n_checks++;
        if (grant === 4'b0001 && grant_id === 2'd0 && busy === 1'b1 && preempt === 1'b0) n_pass++;
        else $display("FAIL reset_first_grant: grant=%b id=%0d busy=%b pre=%b, want 0001/0/1/0", grant, grant_id, busy, preempt);
    endtask

    task automatic test_rotation;
        logic [N-1:0] eg;
        logic         ep;
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            tick(4'b1111, 1'b0);
            eg = 4'b0001 << ((c / MAX_HOLD) % N);
            ep = (c > 0) && (c % MAX_HOLD == 0);
            n_checks++;
            if (grant === eg && grant_id === 2'((c / MAX_HOLD) % N) && busy === 1'b1 && preempt === ep) n_pass++;
            else $display("FAIL rotation c=%0d: grant=%b id=%0d pre=%b, want grant=%b pre=%b", c, grant, grant_id, preempt, eg, ep);
        end
    endtask

    task automatic test_release_handover;
        tick(4'b0000, 1'b1);
        tick(4'b0001, 1'b0);
        tick(4'b1000, 1'b0);
        n_checks++;
        if (grant === 4'b1000 && grant_id === 2'd3 && busy === 1'b1 && preempt === 1'b0) n_pass++;
        else $display("FAIL release_handover: grant=%b id=%0d busy=%b pre=%b, want 1000/3/1/0", grant, grant_id, busy, preempt);
        tick(4'b0000, 1'b0);
        n_checks++;
        if (grant === 4'b0000 && grant_id === 2'd0 && busy === 1'b0 && preempt === 1'b0) n_pass++;
        else $display("FAIL release_to_idle: grant=%b id=%0d busy=%b pre=%b, want 0000/0/0/0", grant, grant_id, busy, preempt);
    endtask

    task automatic test_sole_preempt;
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick(4'b0100, 1'b0);
            n_checks++;
            if (grant === 4'b0100 && grant_id === 2'd2 && preempt === 1'b0) n_pass++;
            else $display("FAIL sole_hold c=%0d: grant=%b id=%0d pre=%b, want 0100/2/0", c, grant, grant_id, preempt);
        end
        tick(4'b0110, 1'b0);
        n_checks++;
        if (grant === 4'b0010 && grant_id === 2'd1 && preempt === 1'b1) n_pass++;
        else $display("FAIL sole_preempt: grant=%b id=%0d pre=%b, want 0010/1/1", grant, grant_id, preempt);
        tick(4'b0110, 1'b0);
        n_checks++;
        if (grant === 4'b0010 && preempt === 1'b0) n_pass++;
        else $display("FAIL preempt_pulse_width: grant=%b pre=%b, want 0010/0", grant, preempt);
    endtask

    task automatic test_midgrant_reset;
        tick(4'b0000, 1'b1);
        tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b1);
        n_checks++;
        if (grant === 4'b0000 && busy === 1'b0 && preempt === 1'b0) n_pass++;
        else $display("FAIL midgrant_reset: grant=%b busy=%b pre=%b, want 0000/0/0", grant, busy, preempt);
        tick(4'b1111, 1'b0);
        n_checks++;
        if (grant === 4'b0001 && grant_id === 2'd0) n_pass++;
        else $display("FAIL reset_prio: grant=%b id=%0d, want 0001/0", grant, grant_id);
    endtask

    task automatic test_idle_wrap;
        tick(4'b0000, 1'b1);
        tick(4'b0100, 1'b0);
        tick(4'b0000, 1'b0);
        n_checks++;
        if (grant === 4'b0000 && busy === 1'b0) n_pass++;
        else $display("FAIL idle_after_release: grant=%b busy=%b, want 0000/0", grant, busy);
        tick(4'b0011, 1'b0);
        n_checks++;
        if (grant === 4'b0001 && grant_id === 2'd0 && busy === 1'b1) n_pass++;
        else $display("FAIL idle_wrap: grant=%b id=%0d busy=%b, want 0001/0/1", grant, grant_id, busy);
    endtask

    task automatic test_random;
        logic [N-1:0] r;
        logic [N-1:0] eg;
        logic         rs;
        r = 4'b0000;
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 99) == 0);
            tick(r, rs);
            eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            n_checks++;
            if (grant === eg && grant_id === 2'((m_owner < 0) ? 0 : m_owner) &&
                busy === (m_owner >= 0) && preempt === m_pre) n_pass++;
            else $display("FAIL random c=%0d req=%b: grant=%b id=%0d busy=%b pre=%b, want grant=%b pre=%b",
                          c, r, grant, grant_id, busy, preempt, eg, m_pre);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_owner  = -1;
        m_ptr    = 0;
        m_held   = 0;
        m_pre    = 1'b0;
        reset    = 1'b1;
        req      = '0;
        test_reset();
        test_rotation();
        test_release_handover();
        test_sole_preempt();
        test_midgrant_reset();
        test_idle_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between N requesters.
- Priority is held in a one-hot ring pointer that rotates to the position after the last owner.
- Grants are registered and one-hot, with a bounded hold time. When the owner exceeds the hold time and another requester is waiting, the owner is pre-empted.
- Sits in front of any shared datapath unit and drives its select lines from grant / grant_id.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation when others are waiting (>= 1).
- ID_W, $clog2(N), width of grant_id (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request vector; req[i] high while requester i wants the resource.
- grant  output  N  registered one-hot grant; all zero when idle.
- grant_id  output  ID_W  binary index of the granted requester; 0 when idle.
- busy  output  1  high whenever grant is non-zero.
- preempt  output  1  one-cycle pulse on the edge where the owner was forcibly rotated out.

Behaviour:
- Internal state:
  - prio: N-bit one-hot ring pointer.
  - hold_cnt: counts 0..MAX_HOLD-1, saturating.
  - FSM with states IDLE and GRANT.
- Reset (sampled at the edge):
  - grant=0, grant_id=0, busy=0, preempt=0.
  - prio=1 (bit 0), hold_cnt=0, state=IDLE.
  - Reset overrides everything, including mid-grant; the owner is dropped with no preempt pulse.
- Winner selection: the lowest circular distance from the prio bit among the candidate bits, searching prio position, +1, ..., wrapping at N-1 -> 0. Selection is combinational; all outputs are registered, so latency is 1 cycle from req to grant.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: grant the winner from req, hold_cnt=0, go to GRANT.
- GRANT, owner g, evaluated each edge in this order:
  - Release: req[g]==0.
    - prio becomes one-hot at (g+1) mod N.
    - Winner is chosen from req using the new prio.
    - If a winner exists: grant it, hold_cnt=0, preempt=0. This is a zero dead-cycle handover.
    - Else: grant=0, go to IDLE.
  - Pre-empt: req[g]==1, hold_cnt==MAX_HOLD-1, and (req & ~grant)!=0.
    - prio becomes one-hot at (g+1) mod N.
    - Winner is chosen from req & ~grant.
    - Grant it, hold_cnt=0, preempt=1 for exactly one cycle.
  - Otherwise: keep the grant.
    - hold_cnt increments, saturating at MAX_HOLD-1.
    - A sole requester therefore keeps the grant indefinitely and can be pre-empted on the first cycle another request appears once its hold has expired.
- Timing: prio updates only on release/pre-empt transitions, never in IDLE. The next IDLE->GRANT search starts after the last owner.
- Invariants:
  - grant is one-hot or zero at all times.
  - grant_id matches grant.
  - busy == |grant.
  - preempt is never high two cycles in a row unless consecutive owners are each pre-empted.
- Requests appearing or disappearing on the same edge as a release/pre-empt use the value of req sampled at that edge.

Test Plan (N=4, MAX_HOLD=4):
- Reset with req=0000 -> grant=0000, grant_id=0, busy=0, preempt=0. Set req=0101 -> next edge grant=0001, grant_id=0, busy=1.
- req=1111 held for 20 cycles after reset -> grant runs 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 ... with a preempt pulse on each switch edge.
- Owner 0 granted, then req changes 0001->1000 -> next edge grant=1000, grant_id=3, preempt=0, no idle cycle. Then req=0000 -> next edge grant=0000, busy=0.
- req=0100 for 10 cycles -> grant=0100 throughout, preempt never asserted. Then req=0110 -> next edge grant=0010 (search from bit 3 wraps to bit 1), preempt=1 for one cycle.
- Reset asserted while grant=0100 -> next edge grant=0000, busy=0, preempt=0. Release reset with req=1111 -> grant=0001 (prio back to bit 0).
- Owner 2 releases with req=0000 (to IDLE), then req=0011 -> grant=0001 (search from bit 3 wraps to bit 0). Confirm the one-hot/zero invariant and grant_id consistency on every cycle of all scenarios.
